serial_tx_arbiter: RTL and testbench

Shares the single `async_transmitter` byte channel of the serial port between up to `NUM_REQ` byte sources, such as the CPU bus write path, a debug monitor and a boot loader echo. Selection is round-robin and the block sequences the transmitter's `TxD_start`/`TxD_busy` handshake. Each source gets a per-byte request/acknowledge handshake. The block sits between the byte sources and the transmitter, replacing direct drive of `TxD_start`/`TxD_data`.

---
 rtl/serial_pkg.sv | 7 +
 rtl/rr_pick.sv | 21 ++
 rtl/serial_tx_arbiter.sv | 72 +++++++
 tb/tb_serial_tx_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and sizing constants for the serial port blocks
package serial_pkg;
  localparam int SER_BYTE_W = 8;
  localparam int SER_MAX_REQ = 8;
  localparam int SER_ID_W = $clog2(SER_MAX_REQ);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} ser_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search for the first request after last_grant
module rr_pick import serial_pkg::*; #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [SER_ID_W-1:0] last_grant,
  output logic [SER_ID_W-1:0] winner,
  output logic                found
);
  // scan from the furthest candidate to the nearest so the nearest set bit is kept
  always_comb begin
    winner = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (|(req & (NUM_REQ'(1) << ((int'(last_grant) + k) % NUM_REQ)))) begin
        winner = SER_ID_W'((int'(last_grant) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of the async_transmitter byte channel
module serial_tx_arbiter import serial_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int START_TIMEOUT = 15,
  parameter int TO_W = 4
) (
  input  logic                           Hclock,
  input  logic                           Hreset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*SER_BYTE_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           tx_start,
  output logic [SER_BYTE_W-1:0]          tx_data,
  input  logic                           tx_busy,
  output logic [SER_ID_W-1:0]            grant_id,
  output logic                           active,
  output logic                           err_timeout,
  input  logic                           err_clr
);
  ser_state_t state, state_nx;
  logic [SER_ID_W-1:0] last_grant, winner;
  logic found, grant, timeout;
  logic [TO_W-1:0] to_cnt;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req),
    .last_grant(last_grant),
    .winner(winner),
    .found(found)
  );

  // grant/timeout strobes and next state; a grant waits for the transmitter to be idle
  always_comb begin
    grant = state == IDLE && found && !tx_busy;
    timeout = state == WAIT_BUSY && !tx_busy && to_cnt == TO_W'(START_TIMEOUT);
    state_nx = state;
    state_nx = grant ? START
      : state == START ? WAIT_BUSY
      : state == WAIT_BUSY ? (tx_busy ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY)
      : state == WAIT_DONE && !tx_busy ? IDLE : state;
  end

  // state register
  always_ff @(posedge Hclock) begin
    if (Hreset) state <= IDLE;
    else state <= state_nx;
  end

  // byte latch, grant bookkeeping, ack pulse, start timeout counter and sticky error
  always_ff @(posedge Hclock) begin
    if (Hreset) begin
      ack <= '0;
      tx_data <= '0;
      grant_id <= '0;
      last_grant <= SER_ID_W'(NUM_REQ - 1);
      to_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      ack <= (state == WAIT_BUSY && tx_busy) ? NUM_REQ'(1) << grant_id : '0;
      to_cnt <= (state == WAIT_BUSY && !tx_busy && !timeout) ? to_cnt + 1'b1 : '0;
      err_timeout <= timeout | (err_timeout & !err_clr);
      if (grant) begin
        grant_id <= winner;
        last_grant <= winner;
        tx_data <= SER_BYTE_W'(req_data >> (SER_BYTE_W * int'(winner)));
      end
    end
  end

  assign tx_start = state == START;
  assign active = state != IDLE;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: randomized scoreboard bench with a transmitter and requester model
module tb_serial_tx_arbiter;
  localparam int N = 3;
  localparam int TMO = 15;

  typedef struct {
    int id;
    logic [7:0] data;
    bit ack;
  } exp_t;

  logic Hclock = 1'b0;
  logic Hreset, tx_busy, err_clr, tx_start, active, err_timeout;
  logic [N-1:0] req, ack;
  logic [N*8-1:0] req_data;
  logic [7:0] tx_data;
  logic [2:0] grant_id;

  int pass_n = 0, total_n = 0;
  int tx_ignore = 0, tx_d = 0, tx_len = 0, m_last = N - 1;
  logic [7:0] rq [N][$];
  logic [7:0] mq [N][$];
  exp_t exq[$];
  exp_t cur;
  bit in_flight = 0, rise, stable, err0;
  int cyc = 0, st, rise_c, nack;

  serial_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TMO), .TO_W(4)) dut (
    .Hclock(Hclock),
    .Hreset(Hreset),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  always #5 Hclock = ~Hclock;

  task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (ok) pass_n++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic load(input int i, input logic [7:0] b);
    rq[i].push_back(b);
    mq[i].push_back(b);
  endtask

  // reference: walk the pending bytes in round-robin order; ignored starts keep the byte
  task automatic plan(input int ign);
    int w;
    while (1) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && mq[(m_last + k) % N].size() > 0) w = (m_last + k) % N;
      if (w < 0) break;
      m_last = w;
      exq.push_back('{w, mq[w][0], ign == 0});
      if (ign > 0) ign--;
      else void'(mq[w].pop_front());
    end
  endtask

  task automatic reset_dut();
    @(negedge Hclock);
    Hreset = 1'b1;
    m_last = N - 1;
    repeat (2) @(negedge Hclock);
    Hreset = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge Hclock);
      if (exq.size() == 0 && !in_flight && !active && rq_empty()) return;
    end
    check(0, "drain", exq.size(), 0);
    exq.delete();
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      mq[i].delete();
    end
  endtask

  // transmitter model: busy rises d cycles after it sees the start pulse, held for len cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge Hclock);
      if (tx_start) begin
        if (tx_ignore > 0) tx_ignore--;
        else begin
          repeat (tx_d != 0 ? tx_d : int'($urandom_range(1, 3))) @(negedge Hclock);
          tx_busy = 1'b1;
          repeat (tx_len != 0 ? tx_len : int'($urandom_range(1, 6))) @(negedge Hclock);
          tx_busy = 1'b0;
        end
      end
    end
  end

  // requesters: hold req while bytes remain, pop on ack, corrupt data while a transfer runs
  initial begin
    logic [7:0] b;
    req = '0;
    req_data = '0;
    forever begin
      @(negedge Hclock);
      for (int i = 0; i < N; i++) begin
        if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        b = rq[i].size() > 0 ? rq[i][0] : 8'h00;
        req[i] = rq[i].size() > 0;
        req_data[8*i +: 8] = active ? ~b : b;
      end
    end
  end

  // monitor: pops an expectation at each start pulse and follows that transfer to its end
  initial begin
    logic [N-1:0] oh;
    bit endx;
    forever begin
      @(posedge Hclock);
      #1;
      cyc++;
      if (Hreset) begin
        check(!tx_start && ack == 0 && !active && tx_data == 0 && grant_id == 0 && !err_timeout,
              "reset_values", {tx_start, ack, active, err_timeout, tx_data, 5'b0, grant_id}, 0);
        in_flight = 0;
      end else begin
        if (in_flight) begin
          if (tx_data != cur.data) stable = 0;
          if (!rise && tx_busy && cyc >= st + 2) begin
            rise = 1;
            rise_c = cyc;
          end
          if (!cur.ack && !err0 && cyc == st + TMO + 1) check(!err_timeout, "err_early", err_timeout, 0);
          endx = cur.ack ? (rise && !tx_busy) : (cyc == st + TMO + 2);
          if (ack != 0) begin
            oh = N'(1) << cur.id;
            check(cur.ack && rise && cyc == rise_c && ack == oh, "ack", ack, cur.ack ? oh : 0);
            nack++;
          end
          if (endx || !active) begin
            check(endx && !active, "release", active, 0);
            check(nack == (cur.ack ? 1 : 0), "ack_count", nack, cur.ack ? 1 : 0);
            check(stable, "data_hold", tx_data, cur.data);
            if (!cur.ack) check(err_timeout, "err_timeout", err_timeout, 1);
            in_flight = 0;
          end
        end else if (ack != 0) check(0, "stray_ack", ack, 0);
        if (tx_start) begin
          check(!in_flight, "start_overlap", in_flight, 0);
          if (exq.size() == 0) check(0, "unexpected_start", tx_data, 0);
          else begin
            cur = exq.pop_front();
            check(tx_data == cur.data, "tx_data", tx_data, cur.data);
            check(grant_id == cur.id, "grant_id", grant_id, cur.id);
            check(!tx_busy, "start_while_busy", tx_busy, 0);
            in_flight = 1;
            st = cyc;
            rise = 0;
            nack = 0;
            stable = 1;
            err0 = err_timeout;
          end
        end
      end
    end
  end

  initial begin
    int ign, cnt;
    Hreset = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(negedge Hclock);
    Hreset = 1'b0;
    tx_d = 1;
    tx_len = 100;
    load(0, 8'h41);
    plan(0);
    wait_idle();
    reset_dut();
    tx_d = 0;
    tx_len = 0;
    load(0, 8'h10);
    load(0, 8'h10);
    load(1, 8'h20);
    load(1, 8'h20);
    plan(0);
    wait_idle();
    load(0, 8'h55);
    plan(0);
    wait_idle();
    reset_dut();
    tx_ignore = 1;
    load(0, 8'($urandom));
    plan(1);
    wait_idle();
    check(err_timeout, "err_sticky", err_timeout, 1);
    @(negedge Hclock);
    err_clr = 1'b1;
    @(negedge Hclock);
    err_clr = 1'b0;
    check(!err_timeout, "err_clr", err_timeout, 0);
    err_clr = 1'b1;
    tx_ignore = 1;
    load(0, 8'($urandom));
    plan(1);
    wait_idle();
    err_clr = 1'b0;
    check(!err_timeout, "err_clr_held", err_timeout, 0);
    for (int v = 0; v < 2; v++) begin
      tx_d = 1;
      tx_len = 40;
      load(0, 8'($urandom));
      plan(0);
      for (int c = 0; c < 200; c++) begin
        @(negedge Hclock);
        if (rq[0].size() == 0) break;
      end
      repeat (3) @(negedge Hclock);
      Hreset = 1'b1;
      m_last = N - 1;
      load(1, 8'($urandom));
      if (v == 1) load(0, 8'($urandom));
      plan(0);
      repeat (2) @(negedge Hclock);
      Hreset = 1'b0;
      tx_d = 0;
      tx_len = 0;
      wait_idle();
    end
    for (int it = 0; it < 30; it++) begin
      cnt = 0;
      for (int i = 0; i < N; i++)
        repeat ($urandom_range(0, 2)) begin
          load(i, 8'($urandom));
          cnt++;
        end
      ign = (cnt > 0 && $urandom_range(0, 4) == 0) ? 1 : 0;
      tx_ignore = ign;
      plan(ign);
      wait_idle();
    end
    repeat (5) @(negedge Hclock);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
